// File: rtl/bsg_mux_one_hot_pipe_pkg.sv
// Shared types for bsg_mux_one_hot_pipe: buffer FSM state encoding.
package bsg_mux_one_hot_pipe_pkg;

    localparam int state_width_lp = 2;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [state_width_lp-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/bsg_mux_one_hot.sv
// AND-OR mux: OR of every element whose select bit is set.
// Zero select yields zero and multi-hot select yields the OR of the chosen elements.
module bsg_mux_one_hot #(
    parameter int width_p = 62,
    parameter int els_p   = 2
) (
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [els_p-1:0]         sel_one_hot_i,
    output logic [width_p-1:0]       data_o
);

    // Gate each element by its select bit and OR the results together
    always_comb begin
        data_o = '0;
        for (int k = 0; k < els_p; k++) begin
            data_o = data_o | (data_i[k*width_p +: width_p] & {width_p{sel_one_hot_i[k]}});
        end
    end

endmodule

// File: rtl/bsg_mux_one_hot_pipe.sv
// One-hot mux followed by a 2-entry output buffer (1-cycle latency).
// ready_o/v_o come straight from flops and never look at yumi_i.
// Optional select checking: define BSG_MUX_ONE_HOT_PIPE_ONEHOT_CHECK_EN to build a
// sticky error_o that flags accepted beats whose select is not exactly one-hot.
module bsg_mux_one_hot_pipe
    import bsg_mux_one_hot_pipe_pkg::*;
#(
    parameter int width_p = 62,
    parameter int els_p   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [els_p-1:0]         sel_one_hot_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic                     error_o
);

    state_e             state;
    logic [width_p-1:0] sel_data;
    logic [width_p-1:0] head;
    logic [width_p-1:0] second;
    logic               v_r;
    logic               ready_r;
    logic               accept;

    bsg_mux_one_hot #(
        .width_p(width_p),
        .els_p  (els_p)
    ) mux (
        .data_i       (data_i),
        .sel_one_hot_i(sel_one_hot_i),
        .data_o       (sel_data)
    );

    assign accept  = v_i & ready_r;
    assign ready_o = ready_r;
    assign v_o     = v_r;
    assign data_o  = head;

    // Buffer FSM; v/ready are registered alongside the state so they mirror it exactly
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= EMPTY;
            head    <= '0;
            second  <= '0;
            v_r     <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head  <= sel_data;
                        state <= ONE;
                        v_r   <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !yumi_i) begin
                        second  <= sel_data;
                        state   <= TWO;
                        ready_r <= 1'b0;
                    end else if (accept && yumi_i) begin
                        // head consumed and replaced in the same cycle
                        head <= sel_data;
                    end else if (yumi_i) begin
                        state <= EMPTY;
                        v_r   <= 1'b0;
                    end
                end
                TWO: begin
                    if (yumi_i) begin
                        head    <= second;
                        state   <= ONE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    v_r     <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef BSG_MUX_ONE_HOT_PIPE_ONEHOT_CHECK_EN
    logic error_r;

    // Sticky flag: any accepted beat with a zero or multi-hot select
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_r <= 1'b0;
        end else if (accept && !$onehot(sel_one_hot_i)) begin
            error_r <= 1'b1;
        end
    end

    assign error_o = error_r;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_mux_one_hot_pipe.sv
// Directed bench for bsg_mux_one_hot_pipe with a scoreboard queue.
// The driver pushes the hand-computed value of each accepted beat; a monitor
// pops and compares whenever the DUT hands a beat over (v_o && yumi_i).
module tb_bsg_mux_one_hot_pipe;

    localparam int W = 62;
    localparam int E = 2;

`ifdef BSG_MUX_ONE_HOT_PIPE_ONEHOT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           v_i;
    logic [E*W-1:0] data_i;
    logic [E-1:0]   sel_one_hot_i;
    logic           ready_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic           yumi_i;
    logic           error_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    bsg_mux_one_hot_pipe #(.width_p(W), .els_p(E)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .data_i       (data_i),
        .sel_one_hot_i(sel_one_hot_i),
        .ready_o      (ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi_i),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: compare each handed-over beat against the scoreboard head
    always @(negedge clk_i) begin
        if (!reset_i && v_o && yumi_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got data_o=%h, required no beat", data_o);
            end else begin
                logic [W-1:0] e;
                e = sb.pop_front();
                if (data_o !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h, required %h", data_o, e);
                end
            end
        end
    end

    // One cycle: drive after posedge, decide acceptance at negedge
    task automatic cyc(input logic rst, input logic v, input logic [E-1:0] sel,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic y, input logic [W-1:0] exp);
        @(posedge clk_i);
        #2;
        reset_i = rst; v_i = v; sel_one_hot_i = sel;
        data_i = {d1, d0}; yumi_i = y;
        @(negedge clk_i);
        if (rst) sb.delete();
        else if (v && ready_o) sb.push_back(exp);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, '0);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; sel_one_hot_i = '0; data_i = '0;

        // reset release
        cyc(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, '0);
        idle();
        chk("rst_v_o", W'(v_o), '0);
        chk("rst_ready_o", W'(ready_o), W'(1));
        chk("rst_error_o", W'(error_o), '0);
        chk("rst_data_o", data_o, '0);

        // single beat selecting element 1
        cyc(1'b0, 1'b1, 2'b10, W'('h155), W'('h3FF), 1'b0, W'('h3FF));
        idle();
        chk("single_v_o", W'(v_o), W'(1));
        chk("single_data_o", data_o, W'('h3FF));
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, '0);
        idle();
        chk("single_v_o_after_pop", W'(v_o), '0);

        // fill and backpressure: C must be dropped while full
        cyc(1'b0, 1'b1, 2'b01, W'(1), W'('h77), 1'b0, W'(1));
        cyc(1'b0, 1'b1, 2'b01, W'(2), W'('h77), 1'b0, W'(2));
        cyc(1'b0, 1'b1, 2'b01, W'(3), W'('h77), 1'b0, W'(3));
        chk("full_ready_o", W'(ready_o), '0);
        chk("full_head", data_o, W'(1));
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, '0);
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, '0);
        idle();
        chk("drain_v_o", W'(v_o), '0);
        chk("drain_ready_o", W'(ready_o), W'(1));

        // simultaneous accept and pop in ONE
        cyc(1'b0, 1'b1, 2'b01, W'(5), '0, 1'b0, W'(5));
        cyc(1'b0, 1'b1, 2'b10, '0, W'(6), 1'b1, W'(6));
        idle();
        chk("swap_v_o", W'(v_o), W'(1));
        chk("swap_ready_o", W'(ready_o), W'(1));
        chk("swap_data_o", data_o, W'(6));
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, '0);
        idle();
        chk("swap_empty", W'(v_o), '0);
        chk("err_before_violation", W'(error_o), '0);

        // multi-hot select, then zero select
        cyc(1'b0, 1'b1, 2'b11, W'('h0F0), W'('h00F), 1'b0, W'('h0FF));
        idle();
        chk("multihot_data_o", data_o, W'('h0FF));
        chk("multihot_error_o", W'(error_o), W'(EXP_ERR));
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, '0);
        cyc(1'b0, 1'b1, 2'b00, W'('h123), W'('h456), 1'b0, '0);
        idle();
        chk("zerosel_v_o", W'(v_o), W'(1));
        chk("zerosel_data_o", data_o, '0);
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, '0);
        idle(); idle(); idle();
        chk("error_sticky", W'(error_o), W'(EXP_ERR));

        // reset while full, with v_i and yumi_i high
        cyc(1'b0, 1'b1, 2'b01, W'(7), '0, 1'b0, W'(7));
        cyc(1'b0, 1'b1, 2'b10, '0, W'(8), 1'b0, W'(8));
        cyc(1'b1, 1'b1, 2'b01, W'(9), '0, 1'b1, '0);
        idle();
        chk("midrst_v_o", W'(v_o), '0);
        chk("midrst_ready_o", W'(ready_o), W'(1));
        chk("midrst_data_o", data_o, '0);
        chk("midrst_error_o", W'(error_o), '0);
        cyc(1'b0, 1'b1, 2'b01, W'('hA), '0, 1'b0, W'('hA));
        idle();
        chk("post_rst_data_o", data_o, W'('hA));
        cyc(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, '0);
        idle();
        chk("post_rst_empty", W'(v_o), '0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d beats, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_mux_one_hot_pipe.md
BSG_MUX_ONE_HOT_PIPE -- requirements
Module: bsg_mux_one_hot_pipe

Interface
REQ-001 SHALL have parameter width_p, default 62: data width per element, at least 1.
REQ-002 SHALL have parameter els_p, default 2: number of input elements, at least 1.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port v_i, input, 1: input beat valid.
REQ-006 SHALL have port data_i, input, els_p*width_p: element k occupies bits [k*width_p +: width_p].
REQ-007 SHALL have port sel_one_hot_i, input, els_p: bit k selects element k.
REQ-008 SHALL have port ready_o, output, 1: the block can accept a beat this cycle.
REQ-009 SHALL have port v_o, output, 1: data_o holds a valid beat.
REQ-010 SHALL have port data_o, output, width_p: selected beat at the head of the buffer.
REQ-011 SHALL have port yumi_i, input, 1: consumer takes the head beat; legal only while v_o=1.
REQ-012 SHALL have port error_o, output, 1: sticky flag for a select violation.

Function
REQ-013 Combinational select SHALL be the bitwise OR over k of (data_i element k AND sel_one_hot_i[k]).
- All-zero select gives zero data.
- Multi-hot select gives the OR of all selected elements.
REQ-014 A beat SHALL be accepted on a cycle with v_i=1 and ready_o=1; its selected value is captured that edge.
REQ-015 Latency SHALL be 1 cycle: an accepted beat appears on data_o with v_o=1 the next cycle when the buffer was empty.
REQ-016 The buffer SHALL be a 2-entry FIFO with FSM states EMPTY, ONE and TWO.
REQ-017 ready_o SHALL equal (state != TWO); it is registered-only and SHALL NOT depend on yumi_i.
REQ-018 FSM transitions: "accept" means a beat is accepted; "pop" means yumi_i=1.
- EMPTY to ONE on accept.
- ONE to TWO on accept without pop.
- ONE to EMPTY on pop without accept.
- ONE stays ONE on simultaneous accept and pop: the head is replaced by the new beat.
- TWO to ONE on pop: the second entry becomes the head.
- All other cases hold state.
REQ-019 Beat order SHALL be preserved; no beat is dropped or duplicated.
REQ-020 v_o SHALL equal (state != EMPTY).
REQ-021 data_o SHALL be driven from a register, not from data_i, and SHALL be stable while v_o=1 and yumi_i=0.
REQ-022 v_i=1 while ready_o=0 SHALL be ignored; no state change.

Reset
REQ-023 While reset_i=1 the state SHALL go to EMPTY at the next edge; after that edge v_o=0, ready_o=1, error_o=0 and data_o=0.
REQ-024 A reset asserted mid-operation SHALL discard all buffered beats and ignore v_i and yumi_i in that cycle.
REQ-025 Data registers SHALL be reset to zero, so data_o is deterministic out of reset.

Configuration
REQ-026 Macro BSG_MUX_ONE_HOT_PIPE_ONEHOT_CHECK_EN SHALL control select checking.
- When defined: on any accepted beat whose select is not exactly one-hot (zero or multi-hot), error_o SHALL set at the next edge and stay set until reset. Data behaviour SHALL still follow REQ-013.
- When undefined: error_o SHALL be tied to 0 and no check logic SHALL be built.

Structure
REQ-027 Package bsg_mux_one_hot_pipe_pkg SHALL hold the FSM state enum (EMPTY, ONE, TWO) and the 2-bit state width constant.
REQ-028 The combinational select SHALL be a sub-module, bsg_mux_one_hot, parameterised by width_p and els_p.
REQ-029 The FSM, the two data registers and the error logic SHALL live in the top module.

Verification
REQ-030 Reset release: reset_i=1 for 2 cycles, then 0 -> v_o=0, ready_o=1, error_o=0, data_o=0.
REQ-031 Single beat: els_p=2, width_p=62, element 1=0x3FF, sel=2'b10, v_i=1 for one cycle -> next cycle v_o=1, data_o=0x3FF; yumi_i=1 -> v_o=0 the following cycle.
REQ-032 Fill and backpressure: three consecutive beats A=1, B=2, C=3 with yumi_i=0 -> ready_o=0 after B, C ignored; popping twice yields 1 then 2, then v_o=0.
REQ-033 Simultaneous accept and pop in state ONE, head=5, new beat=6 -> state stays ONE, data_o=6 next cycle.
REQ-034 Select violation, macro defined: sel=2'b11, element 0=0x0F0, element 1=0x00F -> data_o=0x0FF and error_o=1, sticky until reset. Same stimulus with macro undefined -> error_o=0.
REQ-035 Reset mid-operation: state TWO, reset_i=1 for 1 cycle with v_i=1 and yumi_i=1 -> next cycle v_o=0, ready_o=1; earlier beats never appear.
